// File: rtl/led_scan_controller.sv
// Multiplexed 7-segment scan controller with per-frame shadowing,
// leading-zero suppression, blink and PWM brightness.
module led_scan_controller #(
  parameter int NUM_DIGITS     = 6,
  parameter int SLOT_BITS      = 7,
  parameter int BRIGHT_BITS    = 4,
  parameter int BLANK_CYCLES   = 4,
  parameter int BLINK_FRAMES   = 40,
  parameter bit SEG_ACTIVE_LOW = 0,
  parameter bit DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_enable_mask,
  input  logic [NUM_DIGITS-1:0]   decimal_point_enable_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [7:0]              display_led_segments,
  output logic [NUM_DIGITS-1:0]   display_led_enable_mask,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_BITS-1:0] BLANK_C =
    SLOT_BITS'(BLANK_CYCLES);
  localparam logic [BLK_W-1:0] BLINK_LAST =
    BLK_W'(BLINK_FRAMES - 1);

  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [1:0]           rst_sync;
  logic                 run;

  logic [SLOT_BITS-1:0] slot_cnt;
  logic [IDX_W-1:0]     digit_idx;
  logic                 slot_end;
  logic                 frame_end;

  logic [NUM_DIGITS-1:0][3:0] sh_data;
  logic [NUM_DIGITS-1:0]      sh_den;
  logic [NUM_DIGITS-1:0]      sh_dp;
  logic [NUM_DIGITS-1:0]      sh_blink;
  logic                       sh_lz;
  logic [BRIGHT_BITS-1:0]     sh_bright;

  logic [BLK_W-1:0]     blink_cnt;
  logic                 blink_phase;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic [3:0]            nib;
  logic [7:0]            glyph;
  logic                  past_blank;
  logic                  bright_ok;
  logic                  blink_dark;
  logic                  digit_on;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;

  function automatic logic [7:0] hex_glyph(
    input logic [3:0] n
  );
    logic [7:0] g;
    case (n)
      4'h0: g = 8'b11111100;
      4'h1: g = 8'b01100000;
      4'h2: g = 8'b11011010;
      4'h3: g = 8'b11110010;
      4'h4: g = 8'b01100110;
      4'h5: g = 8'b10110110;
      4'h6: g = 8'b10111110;
      4'h7: g = 8'b11100000;
      4'h8: g = 8'b11111110;
      4'h9: g = 8'b11110110;
      4'hA: g = 8'b11101110;
      4'hB: g = 8'b00111110;
      4'hC: g = 8'b10011100;
      4'hD: g = 8'b01111010;
      4'hE: g = 8'b10011110;
      default: g = 8'b10001110;
    endcase
    return g;
  endfunction

  // Release is synchronised so counting begins on a clean edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  assign slot_end  = (slot_cnt == '1);
  assign frame_end = run && slot_end &&
                     (digit_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (!run) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (frame_end) begin
        digit_idx <= '0;
      end else if (slot_end) begin
        digit_idx <= digit_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_data     <= '0;
      sh_den      <= '0;
      sh_dp       <= '0;
      sh_blink    <= '0;
      sh_lz       <= 1'b0;
      sh_bright   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (frame_end) begin
        sh_data   <= data;
        sh_den    <= digit_enable_mask;
        sh_dp     <= decimal_point_enable_mask;
        sh_blink  <= blink_mask;
        sh_lz     <= lz_suppress;
        sh_bright <= brightness;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // A digit is blank when it and every higher nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (sh_data[k] == 4'h0);
      lz_blank[k] = sh_lz && zero_run && (k != 0);
    end
  end

  assign nib   = sh_data[digit_idx];
  assign glyph = lz_blank[digit_idx] ? 8'h00
                                     : hex_glyph(nib);

  assign past_blank = (slot_cnt >= BLANK_C);
  assign bright_ok  =
    (slot_cnt[SLOT_BITS-1 -: BRIGHT_BITS] < sh_bright);
  assign blink_dark = sh_blink[digit_idx] && !blink_phase;

  assign digit_on = run && past_blank && bright_ok &&
                    sh_den[digit_idx] && !blink_dark;

  always_comb begin
    seg_nxt = 8'h00;
    en_nxt  = '0;
    if (digit_on) begin
      seg_nxt = {glyph[7:1], sh_dp[digit_idx]};
      en_nxt  = NUM_DIGITS'(1) << digit_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      display_led_segments    <= SEG_OFF;
      display_led_enable_mask <= DIG_OFF;
    end else begin
      display_led_segments    <= seg_nxt ^ SEG_OFF;
      display_led_enable_mask <= en_nxt ^ DIG_OFF;
    end
  end

endmodule
